dmem_wait_responder: RTL
========================

Name: dmem_wait_responder

Overview:
- Data-memory responder for the pipeline's MEM stage; serves the mem_read/mem_write requests issued by the EX/MEM buffer.
- Adds a configurable access latency and returns a stall to the hazard/hold logic while an access is in flight.
- Read data is presented to the MEM/WB buffer in the cycle the stall drops.
- Replaces the zero-wait data memory whenever slower memory timing is modelled.

Parameters:
- ADDR_W, 8, word-address width; depth = 2**ADDR_W words of 32 bits.
- LATENCY, 2, stall cycles per access; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_read  in  1  read request from EX/MEM.
- mem_write  in  1  write request from EX/MEM.
- addr  in  32  word address (ALU result from EX/MEM).
- write_data  in  32  store data (rs2 from EX/MEM).
- read_data  out  32  load result, registered.
- stall  out  1  hold request to the pipeline.
- rd_valid  out  1  one-cycle pulse when read_data is updated.
- err  out  1  one-cycle pulse on an illegal access.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; read_data=0, rd_valid=0, err=0; stall=0 while in reset. Any in-flight access is abandoned and a pending write is dropped. Array contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - stall = mem_read | mem_write, combinational, so the pipeline holds in the same cycle the request appears.
  - On a request: capture op, addr and write_data; set cnt=LATENCY-1.
  - Next state is WAIT if LATENCY>1, otherwise DONE.
- WAIT:
  - stall=1; cnt decrements each cycle.
  - At cnt==1 the array access executes on the edge and the FSM goes to DONE.
  - Input changes during WAIT are ignored; only captured values are used.
- Access on the WAIT/IDLE->DONE edge:
  - Write: array[cap_addr] <= cap_data.
  - Read: read_data <= array[cap_addr].
- DONE:
  - stall=0, so the pipeline advances at the end of this cycle.
  - rd_valid=1 if the op was a read.
  - Next state is IDLE unconditionally. The request still visible in DONE is the one just served and is not re-served.
- Timing: a request occupies LATENCY+1 cycles, with stall high for exactly LATENCY of them. Back-to-back requests are served one after another, with each new request first seen in IDLE.
- read_data holds its value until the next completed read; writes do not alter it.
- mem_read and mem_write both high: treat as a write, and pulse err in DONE.
- addr[31:ADDR_W] != 0: out of range.
  - Write is suppressed; a read returns 0.
  - err pulses in DONE; stall timing is unchanged.
- Neither request asserted: stay in IDLE, stall=0, array untouched.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- With the macro defined:
  - A 32-bit free-running cycle counter, reset to 0 and wrapping at 2**32, is mapped at word address 2**ADDR_W-1.
  - A read there returns the counter value sampled on the access edge.
  - A write there is ignored and raises no err.
- Without the macro: that address is ordinary array storage.

Decomposition:
- Shared package dmem_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - the default LATENCY and ADDR_W;
  - the MMIO address offset.
- One sub-module, dmem_array: synchronous-write, synchronous-read 32-bit RAM, no reset. The FSM, capture registers and counter stay in dmem_wait_responder.

Test Plan:
- LATENCY=2: write 0xDEADBEEF to addr 5, then read addr 5 → stall high for exactly 2 cycles per access; on the read's DONE cycle read_data=0xDEADBEEF and rd_valid=1.
- Read addr 5 and change addr to 9 during WAIT → the returned value still comes from addr 5.
- Back-to-back read addr 3 then read addr 4 (preloaded 0x11, 0x22) → 6 cycles total; rd_valid pulses twice with 0x11 then 0x22.
- addr=0x100 write 0x55 with ADDR_W=8 → err pulses once and the array is unchanged; a subsequent read of addr 0x100 → read_data=0, err=1.
- Assert reset low mid-WAIT of a write of 0x77 to addr 2 → stall=0 immediately; a later read of addr 2 returns the prior contents, not 0x77.
- DMEM_MMIO_EN defined: read addr 0xFF twice 10 cycles apart → the difference between the two values is 10; a write to 0xFF → err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-state data memory responder.
// Covers the FSM state encoding, default geometry/latency and the counter mapping.
package dmem_pkg;

    localparam int DMEM_ADDR_W      = 8;
    localparam int DMEM_LATENCY     = 2;
    // The cycle counter sits this many words below the top of the address space.
    localparam int DMEM_MMIO_OFFSET = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Source that read_data currently presents.
    typedef enum logic [1:0] {
        SRC_ZERO  = 2'd0,
        SRC_ARRAY = 2'd1,
        SRC_MMIO  = 2'd2
    } rd_src_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit RAM: synchronous write, registered read, no reset.
// The read register only loads on re, so it holds across writes and idle cycles.
module dmem_array
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_reg [0:(1<<ADDR_W)-1];
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_wait_responder.sv
// MEM-stage data memory with LATENCY stall cycles per access and a registered load result.
// Define DMEM_MMIO_EN to map a free-running cycle counter at the top word address.
module dmem_wait_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        rd_valid,
    output logic        err
);

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              cap_write_reg;
    logic              cap_oor_reg;
    logic              cap_err_reg;
    logic [ADDR_W-1:0] cap_addr_reg;
    logic [31:0]       cap_data_reg;
    rd_src_t           rd_src_reg;

    logic              req;
    logic              in_oor;
    logic              stall_int;
    logic              acc_fire;
    logic              acc_write;
    logic              acc_oor;
    logic              acc_mmio;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_data;
    logic              arr_we;
    logic              arr_re;
    logic [31:0]       arr_rdata;

    assign req    = mem_read | mem_write;
    assign in_oor = (addr[31:ADDR_W] != '0);

    // With LATENCY==1 the access shares its edge with the capture, so it uses the live inputs.
    assign acc_write = (state_reg == IDLE) ? mem_write          : cap_write_reg;
    assign acc_oor   = (state_reg == IDLE) ? in_oor             : cap_oor_reg;
    assign acc_addr  = (state_reg == IDLE) ? addr[ADDR_W-1:0]   : cap_addr_reg;
    assign acc_data  = (state_reg == IDLE) ? write_data         : cap_data_reg;
    assign acc_fire  = ((state_reg == IDLE) && req && (LATENCY == 1)) ||
                       ((state_reg == WAIT) && (cnt_reg == 4'd1));

`ifdef DMEM_MMIO_EN
    localparam logic [ADDR_W-1:0] MMIO_ADDR = ADDR_W'((1 << ADDR_W) - DMEM_MMIO_OFFSET);

    logic [31:0] cycle_cnt_reg;
    logic [31:0] mmio_sample_reg;

    assign acc_mmio = (acc_addr == MMIO_ADDR) && !acc_oor;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_reg   <= '0;
            mmio_sample_reg <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (acc_fire && !acc_write && acc_mmio) begin
                mmio_sample_reg <= cycle_cnt_reg;
            end
        end
    end
`else
    assign acc_mmio = 1'b0;
`endif

    // Gated with reset so nothing reaches the array while the FSM is held.
    assign arr_we = reset & acc_fire &  acc_write & ~acc_oor & ~acc_mmio;
    assign arr_re = reset & acc_fire & ~acc_write & ~acc_oor & ~acc_mmio;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (acc_addr),
        .wdata (acc_data),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_int  = 1'b0;
        case (state_reg)
            IDLE: begin
                stall_int = req;
                if (req) begin
                    cnt_next   = 4'(LATENCY - 1);
                    state_next = (LATENCY > 1) ? WAIT : DONE;
                end
            end
            WAIT: begin
                stall_int = 1'b1;
                cnt_next  = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            cap_write_reg <= 1'b0;
            cap_oor_reg   <= 1'b0;
            cap_err_reg   <= 1'b0;
            cap_addr_reg  <= '0;
            cap_data_reg  <= '0;
            rd_src_reg    <= SRC_ZERO;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if ((state_reg == IDLE) && req) begin
                cap_write_reg <= mem_write;
                cap_oor_reg   <= in_oor;
                cap_err_reg   <= (mem_read & mem_write) | in_oor;
                cap_addr_reg  <= addr[ADDR_W-1:0];
                cap_data_reg  <= write_data;
            end
            if (acc_fire && !acc_write) begin
                rd_src_reg <= acc_oor  ? SRC_ZERO :
                              acc_mmio ? SRC_MMIO : SRC_ARRAY;
            end
        end
    end

    always_comb begin
        read_data = '0;
        case (rd_src_reg)
            SRC_ARRAY: read_data = arr_rdata;
`ifdef DMEM_MMIO_EN
            SRC_MMIO:  read_data = mmio_sample_reg;
`endif
            default:   read_data = '0;
        endcase
    end

    assign stall    = reset & stall_int;
    assign rd_valid = (state_reg == DONE) & ~cap_write_reg;
    assign err      = (state_reg == DONE) &  cap_err_reg;

endmodule
